// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: RISC-V byte-addressed load/store unit driving a word-organised data memory
module lsu_dmem_master #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        we,
  output logic              re,
  output logic [31:0]       dmem_in,
  input  logic [31:0]       dmem_out
);
  typedef enum logic [2:0] {IDLE, LD_ISSUE, LD_CAPTURE, ST_WRITE, RMW_READ, RMW_WRITE, ERR} state_t;
  state_t state_q, state_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] k_q, k_d;
  logic [15:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic re_q, re_d, rv_q, rv_d, err_q, err_d;
  logic [3:0] we_q, we_d;
  logic [31:0] din_q, din_d, rd_q, rd_d;
  logic acc, legal, direct;
  logic [4:0] sh;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] ld, merged;
  logic unused;
  assign unused = ^req_addr[31:ADDR_W+2];
  assign req_ready = state_q == IDLE && !rst;
  assign resp_valid = rv_q;
  assign resp_rdata = rd_q;
  assign resp_err = err_q;
  assign dmem_addr = addr_q;
  assign we = we_q;
  assign re = re_q;
  assign dmem_in = state_q == RMW_WRITE ? merged : din_q;
  always_comb begin
    acc = req_valid && req_ready;
    legal = (req_store ? (req_funct3[2:1] == 2'b00 || req_funct3 == 3'b010)
                       : (req_funct3 != 3'b011 && req_funct3[2:1] != 2'b11))
            && !(req_funct3[1:0] == 2'b01 && req_addr[0])
            && !(req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    direct = req_funct3 == 3'b010 || req_addr[1:0] == 2'b00;
    sh = {k_q, 3'b000};
    b = 8'(dmem_out >> sh);
    h = k_q[1] ? dmem_out[31:16] : dmem_out[15:0];
    ld = f3_q == 3'b000 ? {{24{b[7]}}, b} :
         f3_q == 3'b100 ? {24'b0, b} :
         f3_q == 3'b001 ? {{16{h[15]}}, h} :
         f3_q == 3'b101 ? {16'b0, h} : dmem_out;
    merged = f3_q[0] ? {wdata_q, dmem_out[15:0]}
                     : (dmem_out & ~(32'hFF << sh)) | ({24'b0, wdata_q[7:0]} << sh);
    state_d = state_q;
    f3_d = f3_q;
    k_d = k_q;
    wdata_d = wdata_q;
    addr_d = addr_q;
    re_d = 1'b0;
    we_d = 4'b0000;
    din_d = 32'b0;
    rv_d = 1'b0;
    rd_d = 32'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (acc) begin
        f3_d = req_funct3;
        k_d = req_addr[1:0];
        wdata_d = req_wdata[15:0];
        addr_d = req_addr[ADDR_W+1:2];
        if (!legal) begin
          state_d = ERR;
          rv_d = 1'b1;
          err_d = 1'b1;
        end else if (!req_store) begin
          state_d = LD_ISSUE;
          re_d = 1'b1;
        end else if (direct) begin
          state_d = ST_WRITE;
          we_d = req_funct3 == 3'b010 ? 4'b1111 : req_funct3 == 3'b001 ? 4'b0011 : 4'b0001;
          din_d = req_wdata;
        end else begin
          state_d = RMW_READ;
          re_d = 1'b1;
        end
      end
      LD_ISSUE: state_d = LD_CAPTURE;
      LD_CAPTURE: begin
        state_d = IDLE;
        rv_d = 1'b1;
        rd_d = ld;
      end
      RMW_READ: begin
        state_d = RMW_WRITE;
        we_d = 4'b1111;
      end
      ST_WRITE, RMW_WRITE: begin
        state_d = IDLE;
        rv_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      f3_q <= 3'b0;
      k_q <= 2'b0;
      wdata_q <= 16'b0;
      addr_q <= '0;
      re_q <= 1'b0;
      we_q <= 4'b0;
      din_q <= 32'b0;
      rv_q <= 1'b0;
      rd_q <= 32'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q <= f3_d;
      k_q <= k_d;
      wdata_q <= wdata_d;
      addr_q <= addr_d;
      re_q <= re_d;
      we_q <= we_d;
      din_q <= din_d;
      rv_q <= rv_d;
      rd_q <= rd_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb_lsu_dmem_master: directed self-checking bench for lsu_dmem_master with a registered-read memory model
module tb_lsu_dmem_master;
  logic clk = 1'b0;
  logic rst, req_valid, req_ready, req_store, resp_valid, resp_err, re;
  logic [2:0] req_funct3;
  logic [31:0] req_addr, req_wdata, resp_rdata, dmem_in, dmem_out;
  logic [9:0] dmem_addr;
  logic [3:0] we;
  logic [31:0] mem [0:1023];
  int checks = 0;
  int failures = 0;
  logic re_c [1:4];
  logic rv_c [1:4];
  logic err_c [1:4];
  logic [3:0] we_c [1:4];
  logic [31:0] din_c [1:4];
  logic [31:0] rd_c [1:4];
  logic [9:0] da_c [1:4];
  logic any_re, any_we, any_rv;
  lsu_dmem_master #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dmem_addr(dmem_addr), .we(we), .re(re), .dmem_in(dmem_in), .dmem_out(dmem_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[dmem_addr][8*i +: 8] <= dmem_in[8*i +: 8];
    if (re) dmem_out <= mem[dmem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1;
    req_store = st;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      re_c[c] = re;
      rv_c[c] = resp_valid;
      err_c[c] = resp_err;
      we_c[c] = we;
      din_c[c] = dmem_in;
      rd_c[c] = resp_rdata;
      da_c[c] = dmem_addr;
    end
  endtask
  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
    run(1'b0, f3, a, 32'h0);
    chk({tag, "_re1"}, {31'b0, re_c[1]}, 32'd1);
    chk({tag, "_re_late"}, {30'b0, re_c[2], re_c[3]}, 32'd0);
    chk({tag, "_rv_timing"}, {29'b0, rv_c[1], rv_c[2], rv_c[3]}, 32'b001);
    chk({tag, "_rdata"}, rd_c[3], exp);
    chk({tag, "_err"}, {31'b0, err_c[3]}, 32'd0);
  endtask
  task automatic err_chk(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a);
    run(st, f3, a, 32'hFFFF_FFFF);
    chk({tag, "_rv"}, {30'b0, rv_c[1], rv_c[2]}, 32'b10);
    chk({tag, "_err"}, {31'b0, err_c[1]}, 32'd1);
    chk({tag, "_rdata"}, rd_c[1], 32'd0);
    chk({tag, "_no_re"}, {28'b0, re_c[1], re_c[2], re_c[3], re_c[4]}, 32'd0);
    chk({tag, "_no_we"}, {16'b0, we_c[1], we_c[2], we_c[3], we_c[4]}, 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_funct3 = 3'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_re_we", {27'b0, re, we}, 32'd0);
    chk("rst_dmem_in", dmem_in, 32'd0);
    chk("rst_dmem_addr", {22'b0, dmem_addr}, 32'd0);
    rst = 1'b0;
    run(1'b1, 3'b010, 32'h14, 32'h8899_AABB);
    chk("pre_sw_we", {28'b0, we_c[1]}, 32'hF);
    chk("pre_sw_rv", {29'b0, rv_c[1], rv_c[2], rv_c[3]}, 32'b010);
    load_chk("lb", 3'b000, 32'h15, 32'hFFFF_FFAA);
    load_chk("lbu", 3'b100, 32'h15, 32'h0000_00AA);
    load_chk("lhu", 3'b101, 32'h16, 32'h0000_8899);
    load_chk("lh", 3'b001, 32'h16, 32'hFFFF_8899);
    load_chk("lw", 3'b010, 32'h14, 32'h8899_AABB);
    run(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF);
    chk("sw_addr", {22'b0, da_c[1]}, 32'd8);
    chk("sw_we", {28'b0, we_c[1]}, 32'hF);
    chk("sw_din", din_c[1], 32'hDEAD_BEEF);
    chk("sw_rv", {29'b0, rv_c[1], rv_c[2], rv_c[3]}, 32'b010);
    chk("sw_rdata", rd_c[2], 32'd0);
    load_chk("lw_back", 3'b010, 32'h20, 32'hDEAD_BEEF);
    run(1'b1, 3'b000, 32'h16, 32'h1234_5677);
    chk("sb_rmw_re", {30'b0, re_c[1], re_c[2]}, 32'b10);
    chk("sb_rmw_we1", {28'b0, we_c[1]}, 32'h0);
    chk("sb_rmw_we2", {28'b0, we_c[2]}, 32'hF);
    chk("sb_rmw_din", din_c[2], 32'h8877_AABB);
    chk("sb_rmw_we_after", {24'b0, we_c[3], we_c[4]}, 32'h0);
    chk("sb_rmw_rv", {29'b0, rv_c[1], rv_c[2], rv_c[3]}, 32'b001);
    chk("sb_rmw_mem", mem[5], 32'h8877_AABB);
    run(1'b1, 3'b010, 32'h14, 32'h8899_AABB);
    run(1'b1, 3'b001, 32'h14, 32'h0000_CAFE);
    chk("sh0_we", {28'b0, we_c[1]}, 32'h3);
    chk("sh0_din", din_c[1], 32'h0000_CAFE);
    chk("sh0_rv", {29'b0, rv_c[1], rv_c[2], rv_c[3]}, 32'b010);
    load_chk("sh0_back", 3'b010, 32'h14, 32'h8899_CAFE);
    run(1'b1, 3'b001, 32'h16, 32'h0000_1234);
    chk("sh2_we", {24'b0, we_c[1], we_c[2]}, 32'h0F);
    chk("sh2_din", din_c[2], 32'h1234_CAFE);
    load_chk("sh2_back", 3'b010, 32'h14, 32'h1234_CAFE);
    err_chk("err_lw_mis", 1'b0, 3'b010, 32'h22);
    err_chk("err_sh_mis", 1'b1, 3'b001, 32'h15);
    err_chk("err_f3_011", 1'b0, 3'b011, 32'h14);
    err_chk("err_sbu", 1'b1, 3'b100, 32'h14);
    run(1'b1, 3'b010, 32'h18, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1'b1;
    req_store = 1'b1;
    req_funct3 = 3'b000;
    req_addr = 32'h19;
    req_wdata = 32'h0000_00AB;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_re", {31'b0, re}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_ready", {31'b0, req_ready}, 32'd0);
    chk("rstmid_outs", {26'b0, re, we, resp_valid}, 32'd0);
    chk("rstmid_resp", {resp_rdata[31:1], resp_rdata[0] | resp_err}, 32'd0);
    chk("rstmid_din", dmem_in, 32'd0);
    chk("rstmid_addr", {22'b0, dmem_addr}, 32'd0);
    rst = 1'b0;
    any_we = 1'b0;
    any_rv = 1'b0;
    any_re = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      any_we = any_we | (|we);
      any_rv = any_rv | resp_valid;
      any_re = any_re | re;
    end
    chk("rstmid_no_we", {31'b0, any_we}, 32'd0);
    chk("rstmid_no_rv", {31'b0, any_rv}, 32'd0);
    chk("rstmid_no_re", {31'b0, any_re}, 32'd0);
    chk("rstmid_mem", mem[6], 32'h1122_3344);
    load_chk("rstmid_back", 3'b010, 32'h18, 32'h1122_3344);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
